// File: rtl/cas_pkg.sv
// Shared types and constants for the Acorn 1200-baud cassette tape-signal generator.
package cas_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLeader,
        StCarrier,
        StData
    } cas_state_e;

    localparam int unsigned CAS_CLKS_PER_BIT = 1024;
    localparam int unsigned CAS_FRAME_BITS   = 10;
    localparam int unsigned CAS_LEADER_BITS  = 6144;

    // Square-wave level at count cnt of an n-clock cell: '0' is one full cycle, '1' is two.
    function automatic logic cas_level(input logic bit_v, input int unsigned cnt,
                                       input int unsigned n);
        if (bit_v) begin
            return (cnt < n / 4) || ((cnt >= n / 2) && (cnt < (3 * n) / 4));
        end
        return cnt < n / 2;
    endfunction

endpackage

// File: rtl/cas_tone_cell.sv
// Bit-cell timer and registered square-wave generator; every cell begins with a rising edge.
module cas_tone_cell
    import cas_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CAS_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic start,
    input  logic next_bit,
    output logic cell_end,
    output logic cas_out
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cell_cnt;
    logic [CW-1:0] cnt_d;
    logic          cell_bit;
    logic          bit_d;

    assign cell_end = (cell_cnt == LAST);

    always_comb begin
        cnt_d = cell_end ? '0 : cell_cnt + 1'b1;
        bit_d = cell_end ? next_bit : cell_bit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cell_cnt <= '0;
            cell_bit <= 1'b0;
            cas_out  <= 1'b0;
        end else if (!enable) begin
            cell_cnt <= '0;
            cell_bit <= 1'b0;
            cas_out  <= 1'b0;
        end else if (start) begin
            // First leader cell starts on this edge.
            cell_cnt <= '0;
            cell_bit <= 1'b1;
            cas_out  <= 1'b1;
        end else begin
            cell_cnt <= cnt_d;
            cell_bit <= bit_d;
            cas_out  <= cas_level(bit_d, 32'(cnt_d), CLKS_PER_BIT);
        end
    end

endmodule

// File: rtl/cas_tape_player.sv
// Cassette tape player: leader, carrier and 8N1 frames in 1200/2400 Hz two-tone format.
module cas_tape_player
    import cas_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CAS_CLKS_PER_BIT,
    parameter int unsigned LEADER_BITS  = CAS_LEADER_BITS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       motor_on,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cas_out,
    output logic       leader,
    output logic       busy
);

    localparam logic [3:0] LAST_IDX = 4'(CAS_FRAME_BITS - 1);

    cas_state_e state, state_d;
    logic [15:0] lead_cnt;
    logic [3:0]  bit_idx;
    logic [9:0]  frame;
    logic [7:0]  hold_data;
    logic        hold_full;
    logic        next_bit;
    logic        load;
    logic        accept;
    logic        cell_end;

    assign in_ready = !hold_full && motor_on && !reset;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state;
        next_bit = 1'b1;
        load     = 1'b0;
        if (!motor_on) begin
            state_d = StIdle;
        end else begin
            unique case (state)
                StIdle: state_d = StLeader;
                StLeader: begin
                    if (cell_end && lead_cnt <= 16'd1) begin
                        load    = hold_full;
                        state_d = hold_full ? StData : StCarrier;
                    end
                end
                StCarrier: begin
                    if (cell_end && hold_full) begin
                        load    = 1'b1;
                        state_d = StData;
                    end
                end
                StData: begin
                    if (cell_end) begin
                        if (bit_idx == LAST_IDX) begin
                            load    = hold_full;
                            state_d = hold_full ? StData : StCarrier;
                        end else begin
                            next_bit = frame[bit_idx + 4'd1];
                        end
                    end
                end
            endcase
        end
        // A freshly loaded frame always opens with its start bit.
        if (load) next_bit = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            lead_cnt  <= '0;
            bit_idx   <= '0;
            frame     <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            leader    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state  <= state_d;
            leader <= (state_d == StLeader);
            busy   <= (state_d == StData);
            if (!motor_on) begin
                hold_full <= 1'b0;
                bit_idx   <= '0;
                lead_cnt  <= '0;
            end else begin
                if (state == StIdle) begin
                    lead_cnt <= 16'(LEADER_BITS);
                end else if (state == StLeader && cell_end && lead_cnt != 16'd0) begin
                    lead_cnt <= lead_cnt - 16'd1;
                end
                if (load) begin
                    frame     <= {1'b1, hold_data, 1'b0};
                    bit_idx   <= '0;
                    hold_full <= 1'b0;
                end else if (state_d != StData) begin
                    bit_idx <= '0;
                end else if (cell_end) begin
                    bit_idx <= bit_idx + 4'd1;
                end
                if (accept) begin
                    hold_data <= in_data;
                    hold_full <= 1'b1;
                end
            end
        end
    end

    cas_tone_cell #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tone (
        .clk      (clk),
        .reset    (reset),
        .enable   (motor_on),
        .start    (state == StIdle),
        .next_bit (next_bit),
        .cell_end (cell_end),
        .cas_out  (cas_out)
    );

endmodule

// File: tb/tb_cas_tape_player.sv
// Directed bench for cas_tape_player: cell-by-cell waveform checks from a table of expected cells.
module tb_cas_tape_player;

    localparam int N = 1024;

    typedef struct {
        logic       b;
        logic       ld;
        logic       bz;
        logic       push;
        logic [7:0] data;
    } cell_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       motor_on = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       cas_out;
    logic       leader;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    cell_t tab[$];

    always #5 clk = ~clk;

    cas_tape_player #(
        .CLKS_PER_BIT(N),
        .LEADER_BITS (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .motor_on (motor_on),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cas_out  (cas_out),
        .leader   (leader),
        .busy     (busy)
    );

    function automatic logic lvl(input logic b, input int k);
        if (b) return ((k / (N / 4)) % 2) == 0;
        return k < N / 2;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    function automatic cell_t mk(input logic b, input logic ld, input logic bz,
                                 input logic push, input logic [7:0] data);
        cell_t c;
        c.b = b; c.ld = ld; c.bz = bz; c.push = push; c.data = data;
        return c;
    endfunction

    task automatic add_frame(input logic [7:0] d, input logic push, input logic [7:0] pd);
        tab.push_back(mk(1'b0, 1'b0, 1'b1, push, pd));
        for (int i = 0; i < 8; i++) tab.push_back(mk(d[i], 1'b0, 1'b1, 1'b0, 8'h00));
        tab.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h00));
    endtask

    // Called just before the first sample (count 0) of a cell.
    task automatic run_cell(input cell_t c, input string name);
        int       bad;
        int       first_k;
        logic [2:0] first_act;
        bad = 0;
        first_k = 0;
        first_act = 3'b000;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            if (cas_out !== lvl(c.b, k) || leader !== c.ld || busy !== c.bz) begin
                if (bad == 0) begin
                    first_k = k;
                    first_act = {cas_out, leader, busy};
                end
                bad++;
            end
            if (c.push) begin
                if (k == 10) begin
                    check({name, " in_ready before push"}, in_ready, 1'b1);
                    in_valid = 1'b1;
                    in_data  = c.data;
                end else if (k == 11) begin
                    in_valid = 1'b0;
                end else if (k == 20) begin
                    check({name, " in_ready while buffered"}, in_ready, 1'b0);
                    in_valid = 1'b1;
                    in_data  = 8'h99;
                end else if (k == 30) begin
                    in_valid = 1'b0;
                end
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s: %0d samples wrong, first at count %0d {cas,leader,busy}=%b required %b%b%b",
                     name, bad, first_k, first_act, lvl(c.b, first_k), c.ld, c.bz);
        end
    endtask

    initial begin
        logic [7:0] drop_byte;
        int         bad;
        drop_byte = 8'h0F;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset cas_out", cas_out, 1'b0);
        check("reset in_ready", in_ready, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset leader", leader, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        motor_on = 1'b1;
        repeat (101) @(negedge clk);
        check("pre-reset cas_out high", cas_out, 1'b1);
        reset = 1'b1;
        #1;
        check("mid-cell reset cas_out", cas_out, 1'b0);
        check("mid-cell reset in_ready", in_ready, 1'b0);
        check("mid-cell reset busy", busy, 1'b0);
        check("mid-cell reset leader", leader, 1'b0);
        motor_on = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("post-reset cas_out", cas_out, 1'b0);
        check("post-reset in_ready", in_ready, 1'b0);
        check("post-reset busy", busy, 1'b0);
        check("post-reset leader", leader, 1'b0);

        // Leader with A5 pushed, A5 frame, carrier, back-to-back 00/FF, carrier, start of 0F
        tab.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'hA5));
        for (int i = 0; i < 3; i++) tab.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00));
        add_frame(8'hA5, 1'b0, 8'h00);
        tab.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h00));
        add_frame(8'h00, 1'b1, 8'hFF);
        add_frame(8'hFF, 1'b0, 8'h00);
        tab.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
        tab.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, drop_byte));
        tab.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        for (int i = 0; i < 4; i++) tab.push_back(mk(drop_byte[i], 1'b0, 1'b1, 1'b0, 8'h00));

        motor_on = 1'b1;
        for (int i = 0; i < tab.size(); i++) run_cell(tab[i], $sformatf("cell %0d", i));

        // Motor drop partway through bit 4 of the 0F frame (a '0' cell)
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cas_out !== lvl(drop_byte[4], k) || busy !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL bit4 partial cell: %0d samples wrong, required 0 wrong", bad);
        end
        motor_on = 1'b0;
        @(negedge clk);
        check("drop cas_out", cas_out, 1'b0);
        check("drop in_ready", in_ready, 1'b0);
        check("drop busy", busy, 1'b0);
        check("drop leader", leader, 1'b0);
        repeat (20) @(negedge clk);
        check("motor off cas_out", cas_out, 1'b0);
        check("motor off in_ready", in_ready, 1'b0);

        // Restart: full leader again, then carrier only (discarded byte never emitted)
        motor_on = 1'b1;
        for (int i = 0; i < 4; i++)
            run_cell(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00), $sformatf("restart leader %0d", i));
        for (int i = 0; i < 3; i++)
            run_cell(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00), $sformatf("restart carrier %0d", i));
        check("restart in_ready", in_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
